// File: rtl/status_pkt_generate.sv
// Status packet source for one router input channel: snapshots the status vector,
// frames it as {addr, payload LSB-first, seq} and streams it one byte per clock.
module status_pkt_generate #(
    parameter logic [7:0]  STATUS_ADDR   = 8'h00,
    parameter int unsigned PAYLOAD_BYTES = 2,
    parameter int unsigned PAYLOAD_BITS  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_we,
    input  logic [7:0]              cmd_data,
    input  logic [PAYLOAD_BITS-1:0] status,
    output logic [7:0]              db_out,
    output logic                    rq_out,
    input  logic                    start_out,
    output logic                    busy
);

    localparam int unsigned PAYLOAD_W = 8 * PAYLOAD_BYTES;
    localparam int unsigned SHIFT_W   = PAYLOAD_W + 8;
    localparam int unsigned CNT_W     = 3;
    localparam logic [CNT_W-1:0] PAY_CNT  = CNT_W'(PAYLOAD_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic [1:0]              mode, mode_d;
    logic [5:0]              seq, seq_d;
    logic                    pending, pending_d;
    logic [PAYLOAD_BITS-1:0] last_sent, last_sent_d;
    logic [SHIFT_W-1:0]      shreg, shreg_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [7:0]              db_d;
    logic                    rq_d;
    logic                    busy_d;
    logic                    grant;
    logic [PAYLOAD_W-1:0]    snapshot;

    assign grant    = (state == REQ) && start_out;
    assign snapshot = PAYLOAD_W'(status);

    // Next-state, pending bookkeeping and registered-output values
    always_comb begin
        state_d     = state;
        mode_d      = mode;
        seq_d       = seq;
        pending_d   = pending;
        last_sent_d = last_sent;
        shreg_d     = shreg;
        cnt_d       = cnt;
        db_d        = db_out;
        rq_d        = rq_out;
        busy_d      = busy;

        // Grant consumes the request; auto change detection pauses while streaming
        if (grant) begin
            pending_d = 1'b0;
        end
        if (mode[1] && (status != last_sent) && (state != SEND) && !grant) begin
            pending_d = 1'b1;
        end
        if (cmd_we) begin
            seq_d  = cmd_data[7:2];
            mode_d = cmd_data[1:0];
            if (cmd_data[1:0] == 2'b00) begin
                pending_d = 1'b0;
            end else if (cmd_data[0]) begin
                pending_d = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (pending_d) begin
                    state_d = REQ;
                    db_d    = STATUS_ADDR;
                    rq_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            REQ: begin
                if (start_out) begin
                    state_d     = SEND;
                    db_d        = snapshot[7:0];
                    shreg_d     = SHIFT_W'({seq, 2'b00, snapshot} >> 8);
                    last_sent_d = status;
                    cnt_d       = CNT_W'(1);
                end
            end
            SEND: begin
                if (cnt == LAST_CNT) begin
                    // Final byte has been presented; leave or re-request immediately
                    if (pending_d) begin
                        state_d = REQ;
                        db_d    = STATUS_ADDR;
                        rq_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        db_d    = 8'h00;
                        rq_d    = 1'b0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    db_d    = shreg[7:0];
                    shreg_d = SHIFT_W'(shreg >> 8);
                    cnt_d   = cnt + CNT_W'(1);
                    // rq drops while the seq byte is on the bus to mark end of packet
                    rq_d    = (cnt < PAY_CNT);
                end
            end
            default: begin
                state_d = IDLE;
                db_d    = 8'h00;
                rq_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= 2'b00;
            seq       <= 6'd0;
            pending   <= 1'b0;
            last_sent <= '0;
            shreg     <= '0;
            cnt       <= '0;
            db_out    <= 8'h00;
            rq_out    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            mode      <= mode_d;
            seq       <= seq_d;
            pending   <= pending_d;
            last_sent <= last_sent_d;
            shreg     <= shreg_d;
            cnt       <= cnt_d;
            db_out    <= db_d;
            rq_out    <= rq_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_status_pkt_generate.sv
// Randomised bench for status_pkt_generate against a packet-level reference model.
module tb_status_pkt_generate;

    localparam logic [7:0]  ADDR = 8'h31;
    localparam int unsigned PB   = 2;
    localparam int unsigned BITS = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_we;
    logic [7:0]      cmd_data;
    logic [BITS-1:0] status;
    logic [7:0]      db_out;
    logic            rq_out;
    logic            start_out;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    status_pkt_generate #(
        .STATUS_ADDR   (ADDR),
        .PAYLOAD_BYTES (PB),
        .PAYLOAD_BITS  (BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_we    (cmd_we),
        .cmd_data  (cmd_data),
        .status    (status),
        .db_out    (db_out),
        .rq_out    (rq_out),
        .start_out (start_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 requesting, 2 streaming packet byte m_pos
    int              m_phase;
    int              m_pos;
    logic [7:0]      m_pkt [0:PB+1];
    logic            m_pending;
    logic [1:0]      m_mode;
    logic [5:0]      m_seq;
    logic [BITS-1:0] m_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic we, input logic [7:0] d,
                              input logic [BITS-1:0] st, input logic g);
        logic p;
        logic granted;
        logic [8*PB-1:0] wide;
        if (r) begin
            m_phase = 0; m_pos = 0; m_pending = 1'b0;
            m_mode = 2'b00; m_seq = 6'd0; m_last = '0;
            return;
        end
        granted = (m_phase == 1) && g;
        p = m_pending;
        if (granted) p = 1'b0;
        if (m_mode[1] && st != m_last && m_phase != 2 && !granted) p = 1'b1;
        if (we) begin
            if (d[1:0] == 2'b00) p = 1'b0;
            else if (d[0]) p = 1'b1;
        end
        if (m_phase == 0) begin
            if (p) m_phase = 1;
        end else if (m_phase == 1) begin
            if (granted) begin
                wide = (8*PB)'(st);
                m_pkt[0] = ADDR;
                for (int k = 0; k < int'(PB); k++) m_pkt[k+1] = wide[8*k +: 8];
                m_pkt[PB+1] = {m_seq, 2'b00};
                m_last  = st;
                m_phase = 2;
                m_pos   = 1;
            end
        end else begin
            if (m_pos == int'(PB) + 1) m_phase = p ? 1 : 0;
            else m_pos++;
        end
        if (we) begin
            m_mode = d[1:0];
            m_seq  = d[7:2];
        end
        m_pending = p;
    endtask

    task automatic tick(input logic r, input logic we, input logic [7:0] d,
                        input logic [BITS-1:0] st, input logic g);
        logic [7:0] e_db;
        logic       e_rq;
        logic       e_busy;
        rst = r; cmd_we = we; cmd_data = d; status = st; start_out = g;
        @(posedge clk);
        model_step(r, we, d, st, g);
        #1;
        case (m_phase)
            0: begin e_db = 8'h00; e_rq = 1'b0; e_busy = 1'b0; end
            1: begin e_db = ADDR;  e_rq = 1'b1; e_busy = 1'b1; end
            default: begin
                e_db = m_pkt[m_pos]; e_rq = (m_pos <= int'(PB)); e_busy = 1'b1;
            end
        endcase
        check("db_out", 32'(db_out), 32'(e_db));
        check("rq_out", 32'(rq_out), 32'(e_rq));
        check("busy",   32'(busy),   32'(e_busy));
    endtask

    logic [BITS-1:0] cur;
    int              rq_seen;

    initial begin
        rst = 1'b1; cmd_we = 1'b0; cmd_data = 8'h00; status = '0; start_out = 1'b0;
        tick(1'b1, 1'b0, 8'h00, '0, 1'b0);
        tick(1'b1, 1'b0, 8'h00, '0, 1'b0);
        check("reset_db", 32'(db_out), 32'h0);

        // Single shot: seq 5, grant three cycles into REQ
        cur = 16'hA55A;
        tick(1'b0, 1'b1, {6'd5, 2'b01}, cur, 1'b0);
        check("ss_req_db", 32'(db_out), 32'h31);
        tick(1'b0, 1'b0, 8'h00, cur, 1'b0);
        tick(1'b0, 1'b0, 8'h00, cur, 1'b0);
        tick(1'b0, 1'b0, 8'h00, cur, 1'b1);
        check("ss_b1", 32'(db_out), 32'h5A);
        tick(1'b0, 1'b0, 8'h00, cur, 1'b0);
        check("ss_b2", 32'(db_out), 32'hA5);
        check("ss_b2_rq", 32'(rq_out), 32'h1);
        tick(1'b0, 1'b0, 8'h00, cur, 1'b0);
        check("ss_seq", 32'(db_out), 32'h14);
        check("ss_seq_rq", 32'(rq_out), 32'h0);
        tick(1'b0, 1'b0, 8'h00, cur, 1'b0);
        check("ss_done_busy", 32'(busy), 32'h0);

        // Auto mode: one packet for the new value, then silence while status holds
        cur = 16'h0002;
        tick(1'b0, 1'b1, 8'h02, cur, 1'b0);
        rq_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b0, 8'h00, cur, 1'b1);
            if (i >= 20 && rq_out) rq_seen++;
        end
        check("auto_quiet", 32'(rq_seen), 32'h0);

        // Randomised traffic: commands, status changes, grants, occasional reset
        for (int i = 0; i < 4000; i++) begin
            logic r, we, g;
            logic [7:0] d;
            r  = ($urandom_range(0, 399) == 0);
            we = ($urandom_range(0, 19) == 0);
            d  = 8'($urandom);
            g  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) cur = 16'($urandom);
            tick(r, we, d, cur, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
